// File: rtl/hw_sw_byte_bridge.sv
// hw_sw_byte_bridge: software byte-handshake bridge that assembles 16-byte blocks for a downstream core
// and, when HW_SW_BRIDGE_READBACK_EN is defined, returns result blocks to software one byte per read.
module hw_sw_byte_bridge (
    input  logic         clk_clk,
    input  logic         reset_reset_n,
    input  logic [7:0]   to_hw_port_export,
    input  logic [1:0]   to_hw_sig_export,
    output logic [7:0]   to_sw_port_export,
    output logic [1:0]   to_sw_sig_export,
    output logic [127:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    input  logic [127:0] res_data,
    input  logic         res_valid,
    output logic         res_ready
);
    typedef enum logic [2:0] {IDLE, WR_ACK, RD_ACK, CLR_ACK, HANDOFF} state_t;
    state_t       r_state, w_next;
    logic [127:0] r_wr_buf;
    logic [3:0]   r_wr_cnt;
    logic [7:0]   r_port;
    logic [6:0]   w_wr_base;
    logic         w_wr, w_rd, w_clr;
    assign w_wr      = r_state == IDLE && to_hw_sig_export == 2'b01;
    assign w_rd      = r_state == IDLE && to_hw_sig_export == 2'b10;
    assign w_clr     = r_state == IDLE && to_hw_sig_export == 2'b11;
    assign w_wr_base = 7'd120 - {r_wr_cnt, 3'b000};
    assign blk_data  = r_wr_buf;
    assign to_sw_port_export = r_port;
    // state register
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    // next state and state-decoded status outputs; a wrapped wr_cnt in WR_ACK means byte 15 just landed
    always_comb begin
        w_next = r_state;
        to_sw_sig_export = 2'b00;
        blk_valid = 1'b0;
        case (r_state)
            IDLE: w_next = w_wr ? WR_ACK : w_rd ? RD_ACK : w_clr ? CLR_ACK : IDLE;
            WR_ACK: begin
                to_sw_sig_export = 2'b01;
                if (to_hw_sig_export == 2'b00) w_next = (r_wr_cnt == 4'd0) ? HANDOFF : IDLE;
            end
            RD_ACK: begin
                to_sw_sig_export = 2'b10;
                if (to_hw_sig_export == 2'b00) w_next = IDLE;
            end
            CLR_ACK: begin
                to_sw_sig_export = 2'b01;
                if (to_hw_sig_export == 2'b00) w_next = IDLE;
            end
            HANDOFF: begin
                to_sw_sig_export = 2'b11;
                blk_valid = 1'b1;
                if (blk_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // write buffer fill; clear rewinds the counter but keeps the buffer contents
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            r_wr_buf <= '0;
            r_wr_cnt <= '0;
        end else if (w_wr) begin
            r_wr_buf[w_wr_base +: 8] <= to_hw_port_export;
            r_wr_cnt <= r_wr_cnt + 4'd1;
        end else if (w_clr) begin
            r_wr_cnt <= '0;
        end
`ifdef HW_SW_BRIDGE_READBACK_EN
    logic [127:0] r_rd_buf;
    logic [3:0]   r_rd_cnt;
    logic         r_rd_avail;
    logic [6:0]   w_rd_base;
    assign w_rd_base = 7'd120 - {r_rd_cnt, 3'b000};
    assign res_ready = r_state == IDLE && to_hw_sig_export == 2'b00;
    // result capture and byte-wise readout; a fresh result always overwrites unread data
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) begin
            r_port     <= '0;
            r_rd_buf   <= '0;
            r_rd_cnt   <= '0;
            r_rd_avail <= 1'b0;
        end else begin
            if (w_rd) begin
                r_port <= r_rd_avail ? r_rd_buf[w_rd_base +: 8] : 8'h00;
                if (r_rd_avail) begin
                    r_rd_cnt <= r_rd_cnt + 4'd1;
                    if (r_rd_cnt == 4'd15) r_rd_avail <= 1'b0;
                end
            end
            if (w_clr) begin
                r_rd_cnt   <= '0;
                r_rd_avail <= 1'b0;
            end
            if (res_valid && res_ready) begin
                r_rd_buf   <= res_data;
                r_rd_cnt   <= '0;
                r_rd_avail <= 1'b1;
            end
        end
`else
    logic w_unused_res;
    assign w_unused_res = ^{res_data, res_valid};
    assign res_ready = 1'b0;
    // without readback every read returns zero through the normal handshake
    always_ff @(posedge clk_clk or negedge reset_reset_n)
        if (!reset_reset_n) r_port <= '0;
        else if (w_rd) r_port <= 8'h00;
`endif
endmodule
